// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and MEM/MUL results onto the single register
// file write port. It also tracks pending long-latency writes and bypasses the
// in-flight write into the decode operand path.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int NREG         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [2:0]      alu_wreg,
  input  logic [15:0]     alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [2:0]      mem_wreg,
  input  logic [15:0]     mem_data,
  input  logic            iss_valid,
  input  logic [2:0]      iss_wreg,
  input  logic [2:0]      rega,
  input  logic [2:0]      regb,
  input  logic [15:0]     rf_read1,
  input  logic [15:0]     rf_read2,
  output logic [15:0]     op_a,
  output logic [15:0]     op_b,
  output logic            hazard,
  output logic [NREG-1:0] busy,
  output logic            write_en,
  output logic [2:0]      wreg,
  output logic [15:0]     writedata
);

  // The top register is hardwired and never written.
  localparam logic [2:0] DISCARD_REG = 3'(NREG - 1);
  localparam logic [3:0] LIMIT       = 4'(STARVE_LIMIT);

  logic            r_write_en;
  logic [2:0]      r_wreg;
  logic [15:0]     r_writedata;
  logic [NREG-1:0] r_busy;
  logic [3:0]      r_starve;

  logic            w_forced;
  logic            w_alu_ready;
  logic            w_mem_ready;
  logic            w_alu_acc;
  logic            w_mem_acc;
  logic [3:0]      w_starve_next;
  logic [NREG-1:0] w_busy_next;
  logic            w_wr_next;
  logic [2:0]      w_wreg_next;
  logic [15:0]     w_wdata_next;

  // Handshake arbitration: MEM has priority unless the ALU has starved long enough.
  always_comb begin
    w_forced    = (r_starve == LIMIT);
    w_alu_ready = 1'b0;
    w_mem_ready = 1'b0;
    if (rst_n) begin
      if (w_forced) begin
        w_alu_ready = 1'b1;
        w_mem_ready = ~alu_valid;
      end else begin
        w_alu_ready = ~mem_valid;
        w_mem_ready = 1'b1;
      end
    end
    w_alu_acc = alu_valid & w_alu_ready;
    w_mem_acc = mem_valid & w_mem_ready;
  end

  // Next-state for starvation counter, scoreboard and write port.
  always_comb begin
    w_starve_next = r_starve;
    if (w_alu_acc || !alu_valid) begin
      w_starve_next = 4'd0;
    end else if (mem_valid && w_mem_acc && (r_starve != LIMIT)) begin
      w_starve_next = r_starve + 4'd1;
    end

    // Clear first so that a same-cycle issue to the same register wins.
    w_busy_next = r_busy;
    if (w_mem_acc) begin
      w_busy_next[mem_wreg] = 1'b0;
    end
    if (iss_valid && (iss_wreg != DISCARD_REG)) begin
      w_busy_next[iss_wreg] = 1'b1;
    end

    // Results to the discard register complete the handshake but never write.
    w_wr_next    = 1'b0;
    w_wreg_next  = r_wreg;
    w_wdata_next = r_writedata;
    if (w_mem_acc) begin
      if (mem_wreg != DISCARD_REG) begin
        w_wr_next    = 1'b1;
        w_wreg_next  = mem_wreg;
        w_wdata_next = mem_data;
      end
    end else if (w_alu_acc) begin
      if (alu_wreg != DISCARD_REG) begin
        w_wr_next    = 1'b1;
        w_wreg_next  = alu_wreg;
        w_wdata_next = alu_data;
      end
    end
  end

  // State registers; reset drops any accepted but not yet written result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_en  <= 1'b0;
      r_wreg      <= 3'd0;
      r_writedata <= 16'd0;
      r_busy      <= '0;
      r_starve    <= 4'd0;
    end else begin
      r_write_en  <= w_wr_next;
      r_wreg      <= w_wreg_next;
      r_writedata <= w_wdata_next;
      r_busy      <= w_busy_next;
      r_starve    <= w_starve_next;
    end
  end

  // Bypass the in-flight write so decode sees it before the file commits.
  always_comb begin
    op_a   = (r_write_en && (r_wreg == rega)) ? r_writedata : rf_read1;
    op_b   = (r_write_en && (r_wreg == regb)) ? r_writedata : rf_read2;
    hazard = r_busy[rega] | r_busy[regb];
  end

  assign alu_ready = w_alu_ready;
  assign mem_ready = w_mem_ready;
  assign busy      = r_busy;
  assign write_en  = r_write_en;
  assign wreg      = r_wreg;
  assign writedata = r_writedata;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Write-back stage directly upstream of the 8x16 register file. It merges results from the single-cycle ALU and the multi-cycle memory/multiply unit onto the file's single write port (write_en, wreg, writedata). It also keeps a scoreboard of registers with outstanding long-latency writes. It bypasses the in-flight write into the operand read path, so decode sees up-to-date operands.

Parameters:
STARVE_LIMIT, 4, consecutive cycles ALU may be blocked by MEM before ALU gets forced priority (range 1-15)
NREG, 8, number of architectural registers (fixed at 8; reg 7 is never written)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result available
alu_ready  out  1  ALU result accepted this cycle
alu_wreg  in  3  ALU destination register
alu_data  in  16  ALU result
mem_valid  in  1  MEM/MUL result available
mem_ready  out  1  MEM/MUL result accepted this cycle
mem_wreg  in  3  MEM destination register
mem_data  in  16  MEM result
iss_valid  in  1  long-latency op issued this cycle
iss_wreg  in  3  its destination register
rega, regb  in  3 each  decode read addresses (same as register file)
rf_read1, rf_read2  in  16 each  register file read data
op_a, op_b  out  16 each  bypassed operands
hazard  out  1  rega or regb has a pending long-latency write
busy  out  8  scoreboard, bit r = reg r pending
write_en  out  1  register file write enable (registered)
wreg  out  3  register file write address (registered)
writedata  out  16  register file write data (registered)

Behaviour:
- Reset (async, rst_n=0): write_en=0, wreg=0, writedata=0, busy=0, starve counter=0. All outputs are valid during reset. An accepted but unwritten result is dropped. alu_ready=mem_ready=0 while rst_n=0.
- Accept: at most one result per cycle. A transfer occurs when valid&ready are both high at the rising edge.
- Priority: MEM wins by default. mem_ready=1, alu_ready=~mem_valid, except in forced mode.
- Starve counter: increments when alu_valid&mem_valid and MEM is accepted. It resets to 0 on any ALU accept or when alu_valid=0. When the counter equals STARVE_LIMIT, forced mode applies for one cycle: alu_ready=1 and mem_ready=~alu_valid. The counter saturates at STARVE_LIMIT.
- Output register: on an accept, the next cycle has write_en=1, wreg=dest, writedata=data. Latency is 1 cycle from handshake to write port, and 2 edges until the register file holds the value. With no accept, write_en=0 and wreg/writedata hold their values.
- Reg 7 destination: the handshake completes normally but write_en stays 0 (silently discarded).
- Scoreboard: iss_valid with iss_wreg!=7 sets busy[iss_wreg]. A MEM accept clears busy[mem_wreg]. If set and clear hit the same register in the same cycle, set wins. ALU accepts never touch busy. An issue to reg 7 is ignored.
- hazard = busy[rega] | busy[regb], combinational from current busy.
- Bypass (combinational): op_a = writedata if write_en and wreg==rega, else rf_read1. op_b is the same with regb/rf_read2. This covers the cycle before the register file commits.
- No overflow or underflow conditions. Back-to-back accepts every cycle give full throughput: one write per cycle.

Test Plan:
- Reset mid-write: accept alu r2=0x1234, assert rst_n=0 before next edge -> write_en=0, busy=0x00 immediately; r2 never written.
- Single ALU: alu_valid, r3=0xBEEF, no MEM -> alu_ready=1; next cycle write_en=1, wreg=3, writedata=0xBEEF; rega=3 gives op_a=0xBEEF in that cycle.
- Contention and starvation (STARVE_LIMIT=4): ALU r1=0x0001 and MEM valid continuously with r4, r5, r6, r4 ... -> 4 MEM writes, then ALU r1 written on 5th, then MEM resumes; counter=0.
- Scoreboard: iss r5; rega=5 -> hazard=1, busy=0x20. MEM accept r5=0x00AA -> busy=0x00 after that edge, hazard=0; write_en next cycle with 0x00AA.
- Set/clear collision: MEM accept r5 and iss_valid r5 in the same cycle -> busy[5] stays 1.
- Reg 7: ALU r7=0xFFFF -> alu_ready=1, write_en stays 0, op_a unaffected with rega=7; iss r7 -> busy unchanged.
